// File: rtl/mac_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | mac_pkg : shared FSM state, width defaults and signed limit helper   |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
package mac_pkg;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int DW_DEF = 36;
  localparam int GW_DEF = 4;

  // Working width for the limit helper; any DW+GW up to this is supported.
  localparam int LIM_W = 64;

  typedef enum logic [1:0] {
    LIM_PASS = 2'd0,
    LIM_HI   = 2'd1,
    LIM_LO   = 2'd2
  } lim_e;

  function automatic lim_e limit(input logic signed [LIM_W-1:0] v, input int dw);
    logic signed [LIM_W-1:0] hi;
    logic signed [LIM_W-1:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi)      return LIM_HI;
    else if (v < lo) return LIM_LO;
    else             return LIM_PASS;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_clip.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | sat_clip : combinational DW+GW -> DW signed saturating clipper      |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
module sat_clip
  import mac_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int GW = GW_DEF
) (
  input  logic [DW+GW-1:0] sum_i,
  output logic [DW-1:0]    data_o,
  output logic             sat_o
);

  logic signed [LIM_W-1:0] w_ext;
  lim_e                    w_dir;

  assign w_ext = LIM_W'($signed(sum_i));
  assign w_dir = limit(w_ext, DW);

  always_comb begin
    data_o = sum_i[DW-1:0];
    sat_o  = 1'b0;
    case (w_dir)
      LIM_HI: begin
        data_o = {1'b0, {(DW-1){1'b1}}};
        sat_o  = 1'b1;
      end
      LIM_LO: begin
        data_o = {1'b1, {(DW-1){1'b0}}};
        sat_o  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mac_accum_sat.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | mac_accum_sat : frame accumulator of NTERMS signed products with a   |
// | registered, optionally saturated result (MAC_ACCUM_SATURATE_EN).    |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
module mac_accum_sat
  import mac_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int NTERMS = 4,
  parameter int GW     = GW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_sat
);

  localparam int AW = DW + GW;
  localparam int CW = (NTERMS > 1) ? $clog2(NTERMS) : 1;

  state_e        state_q;
  logic [AW-1:0] acc_q;
  logic [CW-1:0] cnt_q;
  logic          out_valid_q;
  logic [DW-1:0] out_data_q;
  logic          out_sat_q;

  logic [AW-1:0] acc_d;
  logic          w_last;
  logic [DW-1:0] w_lim;
  logic          w_sat;

  assign acc_d  = acc_q + AW'($signed(in_data));
  assign w_last = (cnt_q == CW'(NTERMS - 1));

`ifdef MAC_ACCUM_SATURATE_EN
  sat_clip #(
    .DW (DW),
    .GW (GW)
  ) u_sat_clip (
    .sum_i  (acc_d),
    .data_o (w_lim),
    .sat_o  (w_sat)
  );
`else
  assign w_lim = acc_d[DW-1:0];
  assign w_sat = 1'b0;
`endif

  assign in_ready  = (state_q == ACC);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  // Clear outranks everything, including a same-cycle last-term accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (clear) begin
      state_q     <= ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (in_valid) begin
            if (w_last) begin
              out_data_q  <= w_lim;
              out_sat_q   <= w_sat;
              out_valid_q <= 1'b1;
              acc_q       <= '0;
              cnt_q       <= '0;
              state_q     <= HOLD;
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ACC;
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_accum_sat.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | tb_mac_accum_sat : randomized self-checking bench for mac_accum_sat  |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
module tb_mac_accum_sat;

  localparam int DW     = 36;
  localparam int NTERMS = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sat;

  int checks = 0;
  int errors = 0;

  mac_accum_sat #(.DW(DW), .NTERMS(NTERMS), .GW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  // Reference: exact integer sum, then clip or wrap to DW bits.
  function automatic longint sext(input logic [DW-1:0] d);
    return longint'($signed(d));
  endfunction

  function automatic void model(input longint s, output logic [DW-1:0] d, output logic sat);
`ifdef MAC_ACCUM_SATURATE_EN
    longint hi;
    longint lo;
    hi = (64'sd1 <<< (DW - 1)) - 1;
    lo = -(64'sd1 <<< (DW - 1));
    if (s > hi) begin
      d = hi[DW-1:0]; sat = 1'b1;
    end else if (s < lo) begin
      d = lo[DW-1:0]; sat = 1'b1;
    end else begin
      d = s[DW-1:0]; sat = 1'b0;
    end
`else
    d = s[DW-1:0];
    sat = 1'b0;
`endif
  endfunction

  function automatic logic [DW-1:0] rnd_term(input int mode);
    logic [63:0] r;
    longint      v;
    r = {$urandom(), $urandom()};
    case (mode)
      0: return r[DW-1:0];
      1: begin
        v = longint'($urandom_range(0, 2000)) - 1000;
        return v[DW-1:0];
      end
      default: return r[0] ? 36'h7_FFFF_FFFF : 36'h8_0000_0000;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d, output bit ok);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    ok = (n < 20);
  endtask

  task automatic send_frame(input logic [DW-1:0] t [NTERMS], input int gap_max, output bit ok);
    bit k;
    ok = 1'b1;
    for (int i = 0; i < NTERMS; i++) begin
      repeat ($urandom_range(0, gap_max)) tick();
      push(t[i], k);
      ok &= k;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL reset_out_sat got=%b exp=0", out_sat); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_frame_sum;
    logic [DW-1:0] t [NTERMS];
    bit ok;
    t[0] = 36'd10; t[1] = -36'sd3; t[2] = 36'd7; t[3] = 36'd100;
    out_ready = 1'b1;
    send_frame(t, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sum_accept_timeout got=timeout exp=accept"); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sum_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 36'd114) begin errors++; $display("FAIL sum_data got=%0d exp=114", out_data); end
    checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL sum_sat got=%b exp=0", out_sat); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sum_ready_low got=%b exp=0", in_ready); end
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL sum_release got=ready%b/valid%b exp=ready1/valid0", in_ready, out_valid);
    end
  endtask

  task automatic test_overflow;
    logic [DW-1:0] t [NTERMS];
    logic [DW-1:0] exp_d;
    logic          exp_s;
    bit ok;
    for (int i = 0; i < NTERMS; i++) t[i] = 36'h7_FFFF_FFFF;
`ifdef MAC_ACCUM_SATURATE_EN
    exp_d = 36'h7_FFFF_FFFF; exp_s = 1'b1;
`else
    exp_d = 36'hF_FFFF_FFFC; exp_s = 1'b0;
`endif
    out_ready = 1'b1;
    send_frame(t, 0, ok);
    checks++; if (!ok || out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== exp_d) begin errors++; $display("FAIL ovf_data got=%h exp=%h", out_data, exp_d); end
    checks++; if (out_sat !== exp_s) begin errors++; $display("FAIL ovf_sat got=%b exp=%b", out_sat, exp_s); end
    tick();
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] t [NTERMS];
    logic [DW-1:0] exp_d;
    logic          exp_s;
    longint        s;
    bit ok;
    s = 0;
    for (int i = 0; i < NTERMS; i++) begin t[i] = rnd_term(1); s += sext(t[i]); end
    model(s, exp_d, exp_s);
    out_ready = 1'b0;
    send_frame(t, 1, ok);
    checks++; if (!ok || out_data !== exp_d) begin errors++; $display("FAIL bp_data got=%h exp=%h", out_data, exp_d); end
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = rnd_term(0);
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== exp_d || out_sat !== exp_s || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got=v%b d=%h s=%b r%b exp=v1 d=%h s=%b r0",
                 c, out_valid, out_data, out_sat, in_ready, exp_d, exp_s);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got=ready%b/valid%b exp=ready1/valid0", in_ready, out_valid);
    end
    s = 0;
    for (int i = 0; i < NTERMS; i++) begin t[i] = rnd_term(1); s += sext(t[i]); end
    model(s, exp_d, exp_s);
    send_frame(t, 0, ok);
    checks++; if (!ok || out_data !== exp_d || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_next_frame got=%h exp=%h", out_data, exp_d);
    end
    tick();
  endtask

  task automatic test_clear_collision;
    logic [DW-1:0] t [NTERMS];
    bit ok;
    out_ready = 1'b1;
    push(36'd100, ok); push(36'd200, ok); push(36'd300, ok);
    in_valid = 1'b1; in_data = 36'd400; clear = 1'b1;
    tick();
    in_valid = 1'b0; clear = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL clear_collision got=valid%b/ready%b exp=valid0/ready1", out_valid, in_ready);
    end
    for (int i = 0; i < NTERMS; i++) t[i] = 36'd1;
    send_frame(t, 0, ok);
    checks++; if (!ok || out_valid !== 1'b1 || out_data !== 36'd4) begin
      errors++; $display("FAIL clear_next_frame got=%0d exp=4", out_data);
    end
    tick();
  endtask

  task automatic test_reset_midframe;
    logic [DW-1:0] t [NTERMS];
    bit ok;
    out_ready = 1'b1;
    push(rnd_term(1), ok); push(rnd_term(1), ok);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_sat !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_async got=v%b d=%h s=%b r%b exp=v0 d=0 s=0 r1", out_valid, out_data, out_sat, in_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NTERMS; i++) t[i] = 36'd5;
    send_frame(t, 0, ok);
    checks++; if (!ok || out_valid !== 1'b1 || out_data !== 36'd20) begin
      errors++; $display("FAIL rst_next_frame got=%0d exp=20", out_data);
    end
    tick();
  endtask

  task automatic test_random;
    logic [DW-1:0] t [NTERMS];
    logic [DW-1:0] exp_d;
    logic          exp_s;
    longint        s;
    int            mode;
    bit            ok;
    out_ready = 1'b0;
    for (int f = 0; f < 25; f++) begin
      s = 0;
      mode = $urandom_range(0, 2);
      for (int i = 0; i < NTERMS; i++) begin t[i] = rnd_term(mode); s += sext(t[i]); end
      model(s, exp_d, exp_s);
      send_frame(t, 2, ok);
      checks++; if (!ok || out_valid !== 1'b1 || out_data !== exp_d || out_sat !== exp_s) begin
        errors++; $display("FAIL rand_frame f=%0d got=v%b d=%h s=%b exp=v1 d=%h s=%b", f, out_valid, out_data, out_sat, exp_d, exp_s);
      end
      repeat ($urandom_range(0, 3)) begin
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== exp_d || out_sat !== exp_s) begin
          errors++; $display("FAIL rand_stall f=%0d got=%h exp=%h", f, out_data, exp_d);
        end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rand_consume f=%0d got=%b exp=0", f, out_valid); end
    end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] t [NTERMS];
    logic [DW-1:0] exp_d;
    logic          exp_s;
    longint        s;
    bit            ok;
    out_ready = 1'b1;
    for (int f = 0; f < 6; f++) begin
      s = 0;
      for (int i = 0; i < NTERMS; i++) begin t[i] = rnd_term(0); s += sext(t[i]); end
      model(s, exp_d, exp_s);
      send_frame(t, 0, ok);
      checks++; if (!ok || out_data !== exp_d || out_sat !== exp_s) begin
        errors++; $display("FAIL b2b f=%0d got=%h/%b exp=%h/%b", f, out_data, out_sat, exp_d, exp_s);
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_frame_sum();
    test_overflow();
    test_backpressure();
    test_clear_collision();
    test_reset_midframe();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mac_accum_sat.md
MAC_ACCUM_SAT -- requirements
Module: mac_accum_sat

Interface
REQ-001 The block SHALL have parameter DW, default 36: width of the signed product input and the result output; it matches the multiplier result width.
REQ-002 The block SHALL have parameter NTERMS, default 4: the number of products summed per frame, legal range 1..16.
REQ-003 The block SHALL have parameter GW, default 4: accumulator guard bits, so the accumulator width is DW+GW.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 The block SHALL have port clear, input, 1 bit: synchronous frame abort.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_data carries a product this cycle.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts a product this cycle.
REQ-009 The block SHALL have port in_data, input, DW bits: signed two's-complement product from the upstream multiplier.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data holds a completed frame sum.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the downstream stage consumes out_data.
REQ-012 The block SHALL have port out_data, output, DW bits: signed frame sum, registered.
REQ-013 The block SHALL have port out_sat, output, 1 bit: the frame sum was clipped; valid while out_valid=1.

Function
REQ-014 The FSM SHALL have exactly two states: ACC (accepting products) and HOLD (result pending).
REQ-015 in_ready SHALL be 1 in ACC and 0 in HOLD; a product is accepted only on in_valid & in_ready.
REQ-016 On each accepted product that is not the last term, acc <= acc + sign_extend(in_data) and term count increments.
REQ-017 On the accepted product at count NTERMS-1:
- out_data <= limit(acc + in_data)
- out_valid <= 1
- out_sat updated
- acc <= 0
- count <= 0
- state -> HOLD
REQ-018 The latency SHALL be 1 cycle: out_valid rises on the clock edge that accepts the last term.
REQ-019 In HOLD, out_valid & out_ready SHALL clear out_valid and return the FSM to ACC on that edge; no product is accepted in that cycle.
REQ-020 out_data and out_sat SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 clear=1 SHALL force acc=0, count=0, out_valid=0 and state ACC, with priority over every other event, including a simultaneous last-term accept or output handshake.
REQ-022 With NTERMS=1, every accepted product SHALL produce a result directly.
REQ-023 in_valid in HOLD SHALL be ignored; upstream holds its data until in_ready=1.
REQ-024 The accumulator SHALL never wrap internally for NTERMS <= 2^GW.

Reset
REQ-025 While rst_n=0, the block SHALL hold state=ACC, acc=0, count=0, out_valid=0, out_data=0 and out_sat=0.
REQ-026 Deassertion of rst_n SHALL take effect at a clock edge; reset in the middle of a frame discards any partial sum.

Configuration
REQ-027 When macro MAC_ACCUM_SATURATE_EN is defined, limit() SHALL clip to [-2^(DW-1), 2^(DW-1)-1] and out_sat=1 when clipping occurred.
REQ-028 When MAC_ACCUM_SATURATE_EN is undefined, limit() SHALL truncate to the low DW bits (wrap) and out_sat SHALL be tied to 0.

Structure
REQ-029 The package mac_pkg SHALL hold the FSM state enum (ACC, HOLD), the DW/GW defaults and a limit function for the signed saturation.
REQ-030 The block SHALL have one sub-module, sat_clip, a combinational DW+GW to DW clipper, instantiated only under MAC_ACCUM_SATURATE_EN.
REQ-031 All other logic SHALL reside in mac_accum_sat.

Verification
REQ-032 Frame sum: NTERMS=4, inputs 10, -3, 7, 100, out_ready=1 -> out_data=114 one cycle after the 4th accept, out_sat=0, in_ready low for 1 cycle.
REQ-033 Positive overflow, with macro defined: 4 × 0x7_FFFF_FFFF -> out_data=0x7_FFFF_FFFF, out_sat=1.
REQ-034 Positive overflow, with macro undefined: 4 × 0x7_FFFF_FFFF -> out_data=0xF_FFFF_FFFC, out_sat=0.
REQ-035 Backpressure: out_ready=0 for 5 cycles after a result -> out_data stable, in_ready=0, in_valid ignored; out_ready=1 -> ACC next cycle; the next frame sums correctly from 0.
REQ-036 Clear collision: clear=1 on the cycle of the last-term accept -> out_valid stays 0, and the next frame of 1, 1, 1, 1 yields 4.
REQ-037 Reset mid-frame: 2 terms accepted, then rst_n pulsed low asynchronously -> all outputs 0 immediately; the next frame of 5, 5, 5, 5 yields 20.
